mem_arbiter: RTL and testbench

Shares the core's single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MA). It serialises 1/2/4-byte transfers into byte cycles and assembles little-endian read data, sign- or zero-extending loads. It reports completion to each requester with a one-cycle done pulse. It sits between the IF/MA pipeline stages and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_load_ext.sv | 20 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared width codes, FSM states and owner constants for mem_arbiter
package mem_arbiter_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_MA = 1'b1
   } owner_e;

   // Width code 11 is illegal and runs as a full word.
   function automatic logic [2:0] byte_count(input logic [1:0] w);
      case (w)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter_load_ext.sv
// rtl/mem_arbiter_load_ext.sv - sign/zero extension of a little-endian raw load word
module mem_arbiter_load_ext
   import mem_arbiter_pkg::*;
(
   input  logic [31:0] raw_i,
   input  logic [2:0]  width_i,
   output logic [31:0] data_o
);

   always_comb begin
      case (width_i)
         LB:      data_o = {{24{raw_i[7]}}, raw_i[7:0]};
         LH:      data_o = {{16{raw_i[15]}}, raw_i[15:0]};
         LBU:     data_o = {24'd0, raw_i[7:0]};
         LHU:     data_o = {16'd0, raw_i[15:0]};
         default: data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM port arbiter between IF fetch and MA load/store
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic [31:0]       if_data,
   output logic              if_done,
   input  logic              ma_req,
   input  logic              ma_we,
   input  logic [2:0]        ma_width,
   input  logic [ADDR_W-1:0] ma_addr,
   input  logic [31:0]       ma_wdata,
   output logic [31:0]       ma_rdata,
   output logic              ma_done,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr
);

   state_e            state_q;
   owner_e            own_q;
   logic [2:0]        cnt_q, n_q;
   logic [31:0]       cap_q, cap_d, ext_d;
   logic [31:0]       if_data_q, ma_rdata_q;
   logic [ADDR_W-1:0] mem_a_q;
   logic [7:0]        mem_dout_q, din_hold_q, din_d, wbyte_d;
   logic              mem_wr_q, if_done_q, ma_done_q, adv_q;
   logic              take_ma, take_if;
   logic [1:0]        rd_idx, wr_idx;

   // While frozen the RAM keeps re-sampling mem_a, so keep the byte that arrived for the last advancing edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         adv_q      <= 1'b0;
         din_hold_q <= '0;
      end else begin
         adv_q <= rdy;
         if (adv_q) din_hold_q <= mem_din;
      end
   end

   assign din_d = adv_q ? mem_din : din_hold_q;

   always_comb begin
      rd_idx  = cnt_q[1:0] - 2'd1;
      wr_idx  = cnt_q[1:0] + 2'd1;
      cap_d   = cap_q;
      if (cnt_q != 3'd0) cap_d[{rd_idx, 3'b000} +: 8] = din_d;
      wbyte_d = ma_wdata[{wr_idx, 3'b000} +: 8];
      take_ma = ma_req & ~(if_done_q | ma_done_q);
      take_if = if_req & ~if_flush & ~ma_req & ~(if_done_q | ma_done_q);
   end

   mem_arbiter_load_ext u_load_ext (
      .raw_i   (cap_d),
      .width_i (ma_width),
      .data_o  (ext_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         own_q      <= OWN_IF;
         cnt_q      <= '0;
         n_q        <= '0;
         cap_q      <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
         if_data_q  <= '0;
         ma_rdata_q <= '0;
         if_done_q  <= 1'b0;
         ma_done_q  <= 1'b0;
      end else if (rdy) begin
         if_done_q <= 1'b0;
         ma_done_q <= 1'b0;
         mem_wr_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (take_ma) begin
                  own_q   <= OWN_MA;
                  n_q     <= byte_count(ma_width[1:0]);
                  mem_a_q <= ma_addr;
                  if (ma_we) begin
                     state_q    <= ST_WR;
                     mem_dout_q <= ma_wdata[7:0];
                     mem_wr_q   <= 1'b1;
                  end else begin
                     state_q <= ST_RD;
                  end
               end else if (take_if) begin
                  own_q   <= OWN_IF;
                  n_q     <= 3'd4;
                  mem_a_q <= if_addr;
                  state_q <= ST_RD;
               end
            end
            ST_RD: begin
               if (own_q == OWN_IF && if_flush) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cap_q <= cap_d;
                  if (cnt_q + 3'd1 < n_q) mem_a_q <= mem_a_q + ADDR_W'(1);
                  if (cnt_q == n_q) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                     if (own_q == OWN_IF) begin
                        if_data_q <= cap_d;
                        if_done_q <= 1'b1;
                     end else begin
                        ma_rdata_q <= ext_d;
                        ma_done_q  <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end
            ST_WR: begin
               if (cnt_q + 3'd1 == n_q) begin
                  state_q   <= ST_IDLE;
                  cnt_q     <= '0;
                  ma_done_q <= 1'b1;
               end else begin
                  cnt_q      <= cnt_q + 3'd1;
                  mem_a_q    <= mem_a_q + ADDR_W'(1);
                  mem_dout_q <= wbyte_d;
                  mem_wr_q   <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign if_data  = if_data_q;
   assign if_done  = if_done_q;
   assign ma_rdata = ma_rdata_q;
   assign ma_done  = ma_done_q;
   assign mem_dout = mem_dout_q;
   assign mem_a    = mem_a_q;
   assign mem_wr   = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte-wide RAM model
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, if_req, if_flush, ma_req, ma_we;
   logic [31:0] if_addr, ma_addr, ma_wdata;
   logic [2:0]  ma_width;
   logic [7:0]  mem_din;
   logic [31:0] if_data, ma_rdata, mem_a;
   logic        if_done, ma_done, mem_wr;
   logic [7:0]  mem_dout;

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_data(if_data), .if_done(if_done),
      .ma_req(ma_req), .ma_we(ma_we), .ma_width(ma_width), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
      .ma_rdata(ma_rdata), .ma_done(ma_done),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [0:65535];

   always @(posedge clk) begin
      if (rst) begin
         ram[16'h1000] <= 8'h78; ram[16'h1001] <= 8'h56; ram[16'h1002] <= 8'h34; ram[16'h1003] <= 8'h12;
         ram[16'h1010] <= 8'h80;
         ram[16'h1020] <= 8'h34; ram[16'h1021] <= 8'h92;
         ram[16'h1030] <= 8'h44; ram[16'h1031] <= 8'h33; ram[16'h1032] <= 8'h22; ram[16'h1033] <= 8'h11;
         ram[16'h1040] <= 8'hEF; ram[16'h1041] <= 8'hBE; ram[16'h1042] <= 8'hAD; ram[16'h1043] <= 8'hDE;
      end else if (mem_wr) begin
         ram[mem_a[15:0]] <= mem_dout;
      end
      mem_din <= ram[mem_a[15:0]];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Bit 32 set means the done pulse carries data that must match.
   logic [32:0] exp_if_q[$];
   logic [32:0] exp_ma_q[$];
   logic [32:0] sb_if_e, sb_ma_e;
   int          if_done_n = 0;
   int          ma_done_n = 0;

   always @(negedge clk) begin
      if (if_done && rdy) begin
         if_done_n++;
         if (exp_if_q.size() == 0) check("if_done_unexpected", 32'd1, 32'd0);
         else begin
            sb_if_e = exp_if_q.pop_front();
            check("if_data", if_data, sb_if_e[31:0]);
         end
      end
      if (ma_done && rdy) begin
         ma_done_n++;
         if (exp_ma_q.size() == 0) check("ma_done_unexpected", 32'd1, 32'd0);
         else begin
            sb_ma_e = exp_ma_q.pop_front();
            if (sb_ma_e[32]) check("ma_rdata", ma_rdata, sb_ma_e[31:0]);
         end
      end
   end

   logic [31:0] a_log [0:15];
   logic [7:0]  dout_log [0:15];
   logic        wr_log [0:15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit is_if, input int max, output int lat);
      lat = -1;
      for (int i = 0; i < max; i++) begin
         tick();
         a_log[i]    = mem_a;
         dout_log[i] = mem_dout;
         wr_log[i]   = mem_wr;
         if (is_if ? if_done : ma_done) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic gap();
      tick();
      check("if_done_one_cycle", {31'd0, if_done}, 32'd0);
      check("ma_done_one_cycle", {31'd0, ma_done}, 32'd0);
   endtask

   task automatic ma_start(input logic we, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
      ma_req = 1'b1; ma_we = we; ma_width = w; ma_addr = a; ma_wdata = d;
   endtask

   task automatic ma_load(input string tag, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] exp, input int exp_lat);
      int lat;
      exp_ma_q.push_back({1'b1, exp});
      ma_start(1'b0, w, a, 32'd0);
      wait_done(1'b0, 16, lat);
      ma_req = 1'b0;
      check({tag, "_lat"}, lat, exp_lat);
      gap();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_if_data"}, if_data, 32'd0);
      check({tag, "_ma_rdata"}, ma_rdata, 32'd0);
      check({tag, "_mem_a"}, mem_a, 32'd0);
      check({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
      check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
      check({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
      check({tag, "_ma_done"}, {31'd0, ma_done}, 32'd0);
   endtask

   initial begin
      int lat, n0;
      rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
      ma_req = 1'b0; ma_we = 1'b0; ma_width = 3'b010; ma_addr = '0; ma_wdata = '0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      exp_if_q.push_back({1'b1, 32'h12345678});
      if_addr = 32'h1000; if_req = 1'b1;
      wait_done(1'b1, 16, lat);
      if_req = 1'b0;
      check("if_lat", lat, 32'd5);
      for (int k = 0; k < 4; k++) check("if_mem_a", a_log[k], 32'h1000 + k);
      check("if_no_write", {31'd0, wr_log[0]}, 32'd0);
      gap();

      ma_load("lb",  3'b000, 32'h1010, 32'hFFFFFF80, 2);
      ma_load("lbu", 3'b100, 32'h1010, 32'h00000080, 2);
      ma_load("lh",  3'b001, 32'h1020, 32'hFFFF9234, 3);
      ma_load("lhu", 3'b101, 32'h1020, 32'h00009234, 3);

      exp_ma_q.push_back({1'b0, 32'd0});
      ma_start(1'b1, 3'b010, 32'h2000, 32'hAABBCCDD);
      wait_done(1'b0, 16, lat);
      ma_req = 1'b0;
      check("sw_lat", lat, 32'd4);
      for (int k = 0; k < 4; k++) begin
         check("sw_mem_a", a_log[k], 32'h2000 + k);
         check("sw_mem_wr", {31'd0, wr_log[k]}, 32'd1);
      end
      check("sw_byte0", {24'd0, dout_log[0]}, 32'hDD);
      check("sw_byte1", {24'd0, dout_log[1]}, 32'hCC);
      check("sw_byte2", {24'd0, dout_log[2]}, 32'hBB);
      check("sw_byte3", {24'd0, dout_log[3]}, 32'hAA);
      check("sw_wr_after", {31'd0, wr_log[4]}, 32'd0);
      gap();
      ma_load("sw_readback", 3'b010, 32'h2000, 32'hAABBCCDD, 5);

      exp_ma_q.push_back({1'b0, 32'd0});
      ma_start(1'b1, 3'b000, 32'h2010, 32'h1234565A);
      wait_done(1'b0, 16, lat);
      ma_req = 1'b0;
      check("sb_lat", lat, 32'd1);
      gap();
      ma_load("sb_readback", 3'b100, 32'h2010, 32'h0000005A, 2);

      exp_ma_q.push_back({1'b1, 32'hDEADBEEF});
      exp_if_q.push_back({1'b1, 32'h12345678});
      if_addr = 32'h1000; if_req = 1'b1;
      ma_start(1'b0, 3'b010, 32'h1040, 32'd0);
      wait_done(1'b0, 16, lat);
      ma_req = 1'b0;
      check("both_ma_lat", lat, 32'd5);
      check("both_if_waits", {31'd0, if_done}, 32'd0);
      wait_done(1'b1, 16, lat);
      if_req = 1'b0;
      check("both_if_lat", lat, 32'd6);
      gap();

      if_addr = 32'h1000; if_req = 1'b1;
      tick();
      tick();
      if_flush = 1'b1; if_req = 1'b0;
      tick();
      if_flush = 1'b0;
      n0 = if_done_n;
      repeat (8) tick();
      check("flush_no_done", if_done_n - n0, 32'd0);
      exp_if_q.push_back({1'b1, 32'h11223344});
      if_addr = 32'h1030; if_req = 1'b1;
      wait_done(1'b1, 16, lat);
      if_req = 1'b0;
      check("after_flush_lat", lat, 32'd5);
      gap();

      n0 = ma_done_n;
      ma_start(1'b1, 3'b010, 32'h2020, 32'h11223344);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("rst_mid_store");
      rst = 1'b0; ma_req = 1'b0;
      repeat (6) tick();
      check("rst_no_ma_done", ma_done_n - n0, 32'd0);

      exp_ma_q.push_back({1'b0, 32'd0});
      ma_start(1'b1, 3'b010, 32'h2030, 32'h0A0B0C0D);
      tick();
      tick();
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("frozen_mem_wr", {31'd0, mem_wr}, 32'd0);
         check("frozen_mem_a", mem_a, 32'h2031);
      end
      rdy = 1'b1;
      wait_done(1'b0, 16, lat);
      ma_req = 1'b0;
      check("frozen_sw_lat", lat, 32'd2);
      gap();
      ma_load("frozen_sw_readback", 3'b010, 32'h2030, 32'h0A0B0C0D, 5);

      exp_ma_q.push_back({1'b1, 32'h11223344});
      ma_start(1'b0, 3'b010, 32'h1030, 32'd0);
      tick();
      tick();
      rdy = 1'b0;
      repeat (3) tick();
      rdy = 1'b1;
      wait_done(1'b0, 16, lat);
      ma_req = 1'b0;
      check("frozen_lw_lat", lat, 32'd3);
      gap();

      exp_ma_q.push_back({1'b1, 32'hFFFFFF80});
      ma_start(1'b0, 3'b000, 32'h1010, 32'd0);
      wait_done(1'b0, 16, lat);
      check("stretch_lat", lat, 32'd2);
      rdy = 1'b0;
      repeat (2) begin
         tick();
         check("stretch_done_held", {31'd0, ma_done}, 32'd1);
      end
      rdy = 1'b1; ma_req = 1'b0;
      gap();

      repeat (2) tick();
      check("if_sb_empty", exp_if_q.size(), 32'd0);
      check("ma_sb_empty", exp_ma_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
